// File: rtl/uart_rx_framer.sv
// Framer for STX/LEN/payload/CHK messages from the UART receiver; acks each byte one cycle after consuming it,
// holds a verified frame until frame_ack, and reports aborts as a one-cycle err_strobe with a held err_code.
module uart_rx_framer #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] STX            = 8'h02,
    parameter int         TIMEOUT_CYCLES = 500000,
    localparam int        AW             = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_avail,
    input  logic          rx_error,
    output logic          rx_ack,
    output logic          frame_valid,
    output logic [7:0]    frame_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          frame_ack,
    output logic          err_strobe,
    output logic [2:0]    err_code
);

    localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
    localparam int             DEPTH     = 1 << AW;

    localparam logic [2:0] E_LEN  = 3'd1;
    localparam logic [2:0] E_CHK  = 3'd2;
    localparam logic [2:0] E_TMO  = 3'd3;
    localparam logic [2:0] E_LINE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DONE
    } state_t;

    state_t        state_q;
    logic          rx_ack_q;
    logic          frame_valid_q;
    logic [7:0]    frame_len_q;
    logic [7:0]    idx_q;
    logic [7:0]    chk_q;
    logic [TW-1:0] tmo_q;
    logic          err_strobe_q;
    logic [2:0]    err_code_q;
    logic [7:0]    buf_q [DEPTH];

    logic consume;
    logic line_err;
    logic byte_vld;

    // Blocking on rx_ack_q keeps us off the byte while the receiver is still clearing rx_avail.
    always_comb begin
        consume  = (rx_avail | rx_error) & ~rx_ack_q;
        line_err = consume & rx_error;
        byte_vld = consume & ~rx_error;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            rx_ack_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_len_q   <= 8'd0;
            idx_q         <= 8'd0;
            chk_q         <= 8'd0;
            tmo_q         <= '0;
            err_strobe_q  <= 1'b0;
            err_code_q    <= 3'd0;
        end else begin
            rx_ack_q     <= consume;
            err_strobe_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tmo_q <= '0;
                    if (byte_vld && rx_data == STX) begin
                        state_q <= S_LEN;
                    end
                end
                S_DONE: begin
                    tmo_q <= '0;
                    if (frame_ack) begin
                        state_q       <= S_IDLE;
                        frame_valid_q <= 1'b0;
                    end
                end
                default: begin
                    if (line_err) begin
                        state_q      <= S_IDLE;
                        err_strobe_q <= 1'b1;
                        err_code_q   <= E_LINE;
                        tmo_q        <= '0;
                    end else if (byte_vld) begin
                        // A consumed byte wins over a timeout landing on the same cycle.
                        tmo_q <= '0;
                        case (state_q)
                            S_LEN: begin
                                if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                                    state_q      <= S_IDLE;
                                    err_strobe_q <= 1'b1;
                                    err_code_q   <= E_LEN;
                                end else begin
                                    frame_len_q <= rx_data;
                                    chk_q       <= rx_data;
                                    idx_q       <= 8'd0;
                                    state_q     <= S_PAYLOAD;
                                end
                            end
                            S_PAYLOAD: begin
                                idx_q <= idx_q + 8'd1;
                                chk_q <= chk_q ^ rx_data;
                                if (idx_q == frame_len_q - 8'd1) begin
                                    state_q <= S_CHK;
                                end
                            end
                            S_CHK: begin
                                if (rx_data == chk_q) begin
                                    state_q       <= S_DONE;
                                    frame_valid_q <= 1'b1;
                                end else begin
                                    state_q      <= S_IDLE;
                                    err_strobe_q <= 1'b1;
                                    err_code_q   <= E_CHK;
                                end
                            end
                            default: begin
                                state_q <= S_IDLE;
                            end
                        endcase
                    end else if (tmo_q == TMO_LAST) begin
                        state_q      <= S_IDLE;
                        err_strobe_q <= 1'b1;
                        err_code_q   <= E_TMO;
                        tmo_q        <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_PAYLOAD && byte_vld) begin
            buf_q[idx_q[AW-1:0]] <= rx_data;
        end
    end

    assign rx_ack      = rx_ack_q;
    assign frame_valid = frame_valid_q;
    assign frame_len   = frame_len_q;
    assign rd_data     = buf_q[rd_addr];
    assign err_strobe  = err_strobe_q;
    assign err_code    = err_code_q;

endmodule
